axi4_mid_read_stream_engine: RTL and testbench
==============================================

# axi4_mid_read_stream_engine

Read-side master engine that turns a cacheline read request (base address, line count) into AXI4 MID read bursts (64-bit address, 512-bit data, 1-bit ID) and returns the data as an ordered cacheline stream. Sits between the memory-request logic of a graph processing lane and the AXI4 MID read master port going to the interconnect/HBM. Buffers returned beats in an internal FIFO and uses credit reservation, so `rready` never stalls the interconnect.

## Interface
- `ADDR_W`, 64, address width (matches AXI4 MID address width)
- `DATA_W`, 512, data width; one beat = one 64-byte cacheline
- `MAX_BURST_BEATS`, 64, maximum beats per AR (power of two, ≤256)
- `FIFO_DEPTH`, 256, beat buffer depth (power of two, ≥ MAX_BURST_BEATS)

- `ap_clk`  in  1  clock; all logic on rising edge
- `areset`  in  1  synchronous, active-high reset
- `req_valid` / `req_ready`  in/out  1  request handshake
- `req_addr`  in  64  base byte address; bits [5:0] ignored (treated as 0)
- `req_lines`  in  32  number of cachelines to read
- `m_axi_arvalid` / `m_axi_arready`  out/in  1  AR handshake
- `m_axi_araddr`  out  64  burst start address
- `m_axi_arlen`  out  8  beats-1
- `m_axi_arid` 1, `arsize` 3, `arburst` 2, `arcache` 4, `arprot` 3, `arlock` 2, `arqos` 4, `arregion` 4  out  constants: 0, 3'b110 (64B), 2'b01 INCR, 4'b0011, 0, 0, 0, 0
- `m_axi_rvalid` / `m_axi_rready`  in/out  1  R handshake
- `m_axi_rdata`  in  512; `m_axi_rlast` in 1; `m_axi_rid` in 1 (ignored); `m_axi_rresp` in 2
- `out_valid` / `out_ready`  out/in  1  cacheline stream handshake
- `out_data`  out  512  cacheline; `out_last`  out  1  final line of the request
- `busy`  out  1  state ≠ IDLE
- `resp_error`  out  1  sticky: some beat of current request had `rresp` ≠ OKAY

## Operation
- FSM IDLE → ISSUE → DRAIN → IDLE.
- IDLE: `req_ready`=1. On `req_valid`: latch address (low 6 bits cleared), `remaining`=`req_lines`, clear `resp_error`, `beats_total`=`req_lines`. `req_lines`=0 → stay IDLE, no AR, no output.
- ISSUE: burst beats = min(remaining, MAX_BURST_BEATS, (4096 − addr[11:0])/64); never crosses a 4KB boundary. Computed into registers one cycle before `arvalid` rises.
- Credit rule: `arvalid` asserted only if `reserved + beats ≤ FIFO_DEPTH`; `reserved` = beats issued but not yet popped from the FIFO. Increment by beats on AR handshake, decrement by 1 on each `out` handshake (both in same cycle: net).
- On AR handshake: addr += beats×64, remaining −= beats; remaining = 0 → DRAIN.
- `m_axi_rready` = 1 whenever not in reset; every R beat is pushed into the FIFO (space guaranteed by credits). `rlast` unused for control.
- `rresp` ≠ 2'b00 on any accepted beat → `resp_error`=1 from next cycle until next request accepted; data still forwarded.
- Delivered-beat counter; `out_last`=1 on the beat where count = `beats_total`−1.
- DRAIN: → IDLE when `reserved`=0 (all beats popped).

## Timing
- Reset values: `req_ready` 0, `m_axi_arvalid` 0, `m_axi_rready` 0, `out_valid` 0, `out_last` 0, `busy` 0, `resp_error` 0, all AR fields 0 except constants; FIFO empty, counters 0. `req_ready`=1 first cycle after `areset` falls.
- Request accepted cycle N → first `arvalid` at N+2 (earliest).
- Max one AR every 2 cycles. AR fields stable while `arvalid`=1 and `arready`=0.
- R beat accepted cycle N → `out_valid` at N+1 if FIFO was empty. Output order = AR issue order = R order (single ID).
- `out_valid` held, `out_data` stable, until `out_ready`.
- Reset mid-operation flushes all state; interconnect/slave must be reset by the same `areset` (no stale R beats after reset).

## Configuration
- `AXI4_MID_ENDIAN_SWAP_EN` defined: `out_data` byte i = `m_axi_rdata` byte (63−i) for i=0..63, applied at FIFO write.
- Undefined: `out_data` = `m_axi_rdata` unchanged.

## Test plan
- `req_addr`=0x1000, `req_lines`=1 → one AR araddr 0x1000 arlen 0; one output beat with `out_last`=1; `busy` drops after pop.
- `req_addr`=0x0FC0, `req_lines`=3 → AR1 0x0FC0 arlen 0; AR2 0x1000 arlen 1; three beats, `out_last` on third only.
- `req_addr`=0x0, `req_lines`=200 → ARs at 0x0/0x1000/0x2000/0x3000 with arlen 63/63/63/7; 200 beats in order.
- `out_ready`=0, `req_lines`=512 → exactly 4 ARs (256 beats), `arvalid` stays 0; release `out_ready` → remaining ARs issue, 512 beats, none lost, `rready` never 0.
- `rresp`=2'b10 on beat 2 of 4 → `resp_error`=1 next cycle, stays 1 through DRAIN, cleared on next accepted request; all 4 beats delivered. `req_lines`=0 → no AR, `busy` stays 0.
- Macro defined, `rdata` byte0=0xAA byte63=0x55 → `out_data` byte0=0x55, byte63=0xAA; macro undefined → identical to `rdata`.

Source files
------------

// File: rtl/axi4_mid_read_stream_engine.sv
// AXI4 MID read master: splits a cacheline request into 4KB-safe bursts and streams the beats out in order.
// Optional byte reversal of each beat at FIFO write when AXI4_MID_ENDIAN_SWAP_EN is defined.
module axi4_mid_read_stream_engine #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_BURST_BEATS = 64,
  parameter int FIFO_DEPTH      = 256
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_lines,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic              m_axi_arid,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [1:0]        m_axi_arlock,
  output logic [3:0]        m_axi_arqos,
  output logic [3:0]        m_axi_arregion,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rid,
  input  logic [1:0]        m_axi_rresp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              resp_error,
  output logic [1:0]        dbg_state
);

  localparam int BW  = $clog2(MAX_BURST_BEATS) + 1;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and payload is held stable while valid is high.
  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       remaining_q, beats_total_q, deliv_q;
  logic [BW-1:0]     beats_q, beats_calc;
  logic [7:0]        arlen_q;
  logic              ar_pending_q, resp_error_q;
  logic [CW-1:0]     reserved_q, count_q;
  logic [FAW-1:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] wdata;
  logic [6:0]        page_beats;
  logic [31:0]       cand;
  logic [CW:0]       credit_sum;
  logic              credit_ok, req_hs, ar_hs, r_hs, out_hs;
  logic              unused_bits;

  assign unused_bits = ^{m_axi_rid, m_axi_rlast, req_addr[5:0], cand[31:BW]};

  assign req_hs = req_valid && req_ready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign out_hs = out_valid && out_ready;

  // Beats left before the next 4KB page boundary (address is line aligned).
  assign page_beats = 7'd64 - {1'b0, addr_q[11:6]};

  always_comb begin
    cand = 32'(MAX_BURST_BEATS);
    if ({25'd0, page_beats} < cand) cand = {25'd0, page_beats};
    if (remaining_q < cand) cand = remaining_q;
    beats_calc = cand[BW-1:0];
  end

  // Credits count every beat issued and not yet popped, so the FIFO can never overflow.
  assign credit_sum = {1'b0, reserved_q} + (CW+1)'(beats_q);
  assign credit_ok  = credit_sum <= (CW+1)'(FIFO_DEPTH);

  always_comb begin
    wdata = m_axi_rdata;
`ifdef AXI4_MID_ENDIAN_SWAP_EN
    for (int i = 0; i < DATA_W/8; i++) begin
      wdata[i*8 +: 8] = m_axi_rdata[(DATA_W/8-1-i)*8 +: 8];
    end
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_hs && req_lines != 32'd0) state_nx = S_ISSUE;
      S_ISSUE: if (ar_hs && remaining_q == 32'(beats_q)) state_nx = S_DRAIN;
      S_DRAIN: if (reserved_q == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign req_ready      = (state == S_IDLE) && !areset;
  assign m_axi_rready   = !areset;
  assign m_axi_arvalid  = (state == S_ISSUE) && ar_pending_q && credit_ok;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = arlen_q;
  assign m_axi_arid     = 1'b0;
  assign m_axi_arsize   = 3'b110;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arlock   = 2'b00;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;
  assign out_valid      = (count_q != '0);
  assign out_data       = mem[rd_ptr];
  assign out_last       = out_valid && (deliv_q == beats_total_q - 32'd1);
  assign busy           = (state != S_IDLE);
  assign resp_error     = resp_error_q;
  assign dbg_state      = state;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_total_q <= '0;
      deliv_q       <= '0;
      beats_q       <= '0;
      arlen_q       <= '0;
      ar_pending_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      reserved_q    <= '0;
      count_q       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      state <= state_nx;
      if (req_hs) begin
        addr_q        <= {req_addr[ADDR_W-1:6], 6'b0};
        remaining_q   <= req_lines;
        beats_total_q <= req_lines;
        deliv_q       <= '0;
      end else if (state == S_ISSUE && !ar_pending_q) begin
        // Burst size is registered a cycle ahead so arvalid never sees the min() path.
        beats_q      <= beats_calc;
        arlen_q      <= 8'(beats_calc - 1'b1);
        ar_pending_q <= 1'b1;
      end else if (ar_hs) begin
        ar_pending_q <= 1'b0;
        addr_q       <= addr_q + (ADDR_W'(beats_q) << 6);
        remaining_q  <= remaining_q - 32'(beats_q);
      end
      reserved_q <= reserved_q + (ar_hs ? CW'(beats_q) : '0) - (out_hs ? CW'(1) : '0);
      count_q    <= count_q + CW'(r_hs) - CW'(out_hs);
      if (r_hs) wr_ptr <= wr_ptr + 1'b1;
      if (out_hs) begin
        rd_ptr  <= rd_ptr + 1'b1;
        deliv_q <= deliv_q + 32'd1;
      end
      if (req_hs) resp_error_q <= 1'b0;
      else if (r_hs && m_axi_rresp != 2'b00) resp_error_q <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (r_hs) mem[wr_ptr] <= wdata;
  end

endmodule

// File: tb/tb_axi4_mid_read_stream_engine.sv
// Directed bench for axi4_mid_read_stream_engine with a behavioural AXI read slave and an in-order scoreboard.
// Expected data follows AXI4_MID_ENDIAN_SWAP_EN when the macro is defined for the build.
module tb_axi4_mid_read_stream_engine;
  localparam int DW = 512;

  logic          ap_clk = 1'b0;
  logic          areset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [63:0]   req_addr = '0;
  logic [31:0]   req_lines = '0;
  logic          m_axi_arvalid, m_axi_arready = 1'b1;
  logic [63:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_arid;
  logic [2:0]    m_axi_arsize, m_axi_arprot;
  logic [1:0]    m_axi_arburst, m_axi_arlock;
  logic [3:0]    m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic          m_axi_rvalid = 1'b0, m_axi_rready;
  logic [DW-1:0] m_axi_rdata = '0;
  logic          m_axi_rlast = 1'b0, m_axi_rid = 1'b0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          out_valid, out_ready = 1'b1, out_last, busy, resp_error;
  logic [DW-1:0] out_data;
  logic [1:0]    dbg_state;

  axi4_mid_read_stream_engine dut (
    .ap_clk(ap_clk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_lines(req_lines),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .resp_error(resp_error), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 ap_clk = ~ap_clk;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int r_cnt = 0, err_beat = -1, rready_drop = 0;
  bit force_en = 1'b0;
  logic [DW-1:0] force_data = '0;

  logic [63:0]   ar_addr_q[$];
  logic [7:0]    ar_len_q[$];
  logic [63:0]   r_q[$];
  logic [DW-1:0] got_data_q[$];
  logic          got_last_q[$];
  logic [DW-1:0] exp_q[$];

  // Handshake monitors at the falling edge: what is seen here completes on the next rising edge.
  always @(negedge ap_clk) begin
    if (!areset && m_axi_arvalid && m_axi_arready) begin
      ar_addr_q.push_back(m_axi_araddr);
      ar_len_q.push_back(m_axi_arlen);
      for (int i = 0; i <= int'(m_axi_arlen); i++) r_q.push_back(m_axi_araddr + 64'(i) * 64);
    end
    if (!areset && out_valid && out_ready) begin
      got_data_q.push_back(out_data);
      got_last_q.push_back(out_last);
    end
    if (!areset && m_axi_rready !== 1'b1) rready_drop++;
  end

  // Read slave: one beat per cycle from the pending-beat queue.
  initial begin
    logic [63:0] a;
    forever begin
      @(posedge ap_clk);
      #1;
      if (areset || r_q.size() == 0) begin
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
      end else begin
        a = r_q.pop_front();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = force_en ? force_data : {8{a}};
        force_en     = 1'b0;
        m_axi_rresp  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (r_q.size() == 0);
        r_cnt++;
      end
    end
  end

  function automatic logic [DW-1:0] xform(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef AXI4_MID_ENDIAN_SWAP_EN
    for (int i = 0; i < DW/8; i++) r[i*8 +: 8] = d[(DW/8-1-i)*8 +: 8];
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_req(input logic [63:0] addr, input logic [31:0] lines);
    bit ok;
    @(posedge ap_clk); #1;
    req_valid = 1'b1; req_addr = addr; req_lines = lines;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge ap_clk);
      if (req_ready) ok = 1'b1;
    end
    chk("req_accept", ok, 1);
    @(posedge ap_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge ap_clk);
      if (!busy && r_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); got_data_q.delete(); got_last_q.delete();
  endtask

  // Scoreboard: expected stream for a request, compared beat by beat against what was popped.
  task automatic check_stream(input string tag, input logic [63:0] base, input int lines);
    int data_err, last_err;
    exp_q.delete();
    for (int i = 0; i < lines; i++) exp_q.push_back(xform({8{base + 64'(i) * 64}}));
    chk({tag, "_count"}, got_data_q.size(), lines);
    data_err = 0; last_err = 0;
    for (int i = 0; i < lines && got_data_q.size() > 0; i++) begin
      if (got_data_q.pop_front() !== exp_q.pop_front()) data_err++;
      if (got_last_q.pop_front() !== (i == lines - 1)) last_err++;
    end
    chk({tag, "_data_errs"}, data_err, 0);
    chk({tag, "_last_errs"}, last_err, 0);
  endtask

  initial begin
    bit seen, any_busy, any_ar;
    logic [DW-1:0] fd, od;

    // Reset values
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_ar_consts", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot,
                          m_axi_arlock, m_axi_arqos, m_axi_arregion}, {1'b0, 3'b110, 2'b01, 4'b0011, 3'b0, 2'b0, 4'b0, 4'b0});
    chk("rst_state", dbg_state, 0);
    @(posedge ap_clk); #1;
    areset = 1'b0;
    @(negedge ap_clk);
    chk("req_ready_after_rst", req_ready, 1);

    // Single line, with request-to-AR latency
    clear_logs();
    send_req(64'h1000, 1);
    @(negedge ap_clk);
    chk("ar_lat_n1", m_axi_arvalid, 0);
    @(negedge ap_clk);
    chk("ar_lat_n2", m_axi_arvalid, 1);
    wait_idle(200);
    chk("t1_ar_count", ar_addr_q.size(), 1);
    chk("t1_araddr", ar_addr_q[0], 64'h1000);
    chk("t1_arlen", ar_len_q[0], 0);
    check_stream("t1", 64'h1000, 1);
    chk("t1_busy", busy, 0);

    // Page crossing split
    clear_logs();
    send_req(64'h0FC0, 3);
    wait_idle(200);
    chk("t2_ar_count", ar_addr_q.size(), 2);
    chk("t2_ar0", {ar_addr_q[0], ar_len_q[0]}, {64'h0FC0, 8'd0});
    chk("t2_ar1", {ar_addr_q[1], ar_len_q[1]}, {64'h1000, 8'd1});
    check_stream("t2", 64'h0FC0, 3);

    // Max burst length and remainder
    clear_logs();
    send_req(64'h0, 200);
    wait_idle(1000);
    chk("t3_ar_count", ar_addr_q.size(), 4);
    chk("t3_ar0", {ar_addr_q[0], ar_len_q[0]}, {64'h0000, 8'd63});
    chk("t3_ar1", {ar_addr_q[1], ar_len_q[1]}, {64'h1000, 8'd63});
    chk("t3_ar2", {ar_addr_q[2], ar_len_q[2]}, {64'h2000, 8'd63});
    chk("t3_ar3", {ar_addr_q[3], ar_len_q[3]}, {64'h3000, 8'd7});
    check_stream("t3", 64'h0, 200);

    // Credit backpressure: output stalled, FIFO fills, issue stops at 256 beats
    clear_logs();
    out_ready = 1'b0;
    send_req(64'h10000, 512);
    repeat (400) @(negedge ap_clk);
    chk("t4_ar_count_blocked", ar_addr_q.size(), 4);
    chk("t4_arvalid_blocked", m_axi_arvalid, 0);
    chk("t4_nothing_out", got_data_q.size(), 0);
    chk("t4_out_valid", out_valid, 1);
    @(posedge ap_clk); #1;
    out_ready = 1'b1;
    wait_idle(3000);
    chk("t4_ar_count", ar_addr_q.size(), 8);
    check_stream("t4", 64'h10000, 512);

    // Error response on the second beat of four
    clear_logs();
    out_ready = 1'b0;
    err_beat = r_cnt + 1;
    send_req(64'h2000, 4);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge ap_clk);
      if (m_axi_rvalid && m_axi_rresp != 2'b00) seen = 1'b1;
    end
    chk("t5_err_beat_seen", seen, 1);
    chk("t5_err_before", resp_error, 0);
    @(negedge ap_clk);
    chk("t5_err_next", resp_error, 1);
    repeat (10) @(negedge ap_clk);
    chk("t5_drain_state", dbg_state, 2);
    chk("t5_err_in_drain", resp_error, 1);
    @(posedge ap_clk); #1;
    out_ready = 1'b1;
    wait_idle(200);
    chk("t5_err_sticky", resp_error, 1);
    check_stream("t5", 64'h2000, 4);

    // Zero-line request: clears the error, no AR, never busy
    clear_logs();
    send_req(64'h3000, 0);
    any_busy = 1'b0; any_ar = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      if (busy) any_busy = 1'b1;
      if (m_axi_arvalid) any_ar = 1'b1;
    end
    chk("t6_busy", any_busy, 0);
    chk("t6_arvalid", any_ar, 0);
    chk("t6_err_cleared", resp_error, 0);
    chk("t6_no_output", got_data_q.size(), 0);

    // Byte order of a marked beat
    clear_logs();
    fd = '0;
    fd[7:0] = 8'hAA;
    fd[511:504] = 8'h55;
    fd[15:8] = 8'h12;
    force_data = fd;
    force_en = 1'b1;
    send_req(64'h5000, 1);
    wait_idle(200);
    chk("t7_count", got_data_q.size(), 1);
    od = (got_data_q.size() > 0) ? got_data_q[0] : '0;
`ifdef AXI4_MID_ENDIAN_SWAP_EN
    chk("t7_byte0", od[7:0], 8'h55);
    chk("t7_byte63", od[511:504], 8'hAA);
    chk("t7_byte62", od[503:496], 8'h12);
`else
    chk("t7_byte0", od[7:0], 8'hAA);
    chk("t7_byte63", od[511:504], 8'h55);
    chk("t7_byte1", od[15:8], 8'h12);
`endif
    chk("t7_full", od, xform(fd));

    chk("rready_never_low", rready_drop, 0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
